// File: rtl/i2c_eeprom_slave_if.sv
// SCL plus the responder's status/debug outputs, bundled for the I2C EEPROM responder.
// SDA stays a plain inout on the top module so the open-drain wire resolves at the bus.
interface i2c_eeprom_slave_if #(
  parameter int unsigned MEM_AW = 8
);
  logic              i2c_sclk;
  logic              sda_oe;
  logic              busy;
  logic              wr_pulse;
  logic              rd_pulse;
  logic [MEM_AW-1:0] cur_addr;

  modport master (output i2c_sclk, input sda_oe, busy, wr_pulse, rd_pulse, cur_addr);
  modport slave  (input i2c_sclk, output sda_oe, busy, wr_pulse, rd_pulse, cur_addr);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// I2C responder modelling a 2-byte-addressed serial EEPROM, oversampled on clk.
// Define I2C_SLAVE_SEQ_READ_EN to continue reads on master ACK (default: single-byte read).
module i2c_eeprom_slave #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_eeprom_slave_if.slave bus,
  inout  wire               i2c_sdat
);

  localparam int unsigned Depth = 2 ** MEM_AW;

  typedef enum logic [3:0] {
    StIdle, StDev, StAckDev, StAddrHi, StAckHi, StAddrLo, StAckLo,
    StWrData, StAckWr, StRdLoad, StRdData, StRdAck
  } state_e;

  state_e            state_q;
  logic              scl_s1_q, scl_s2_q, scl_h_q;
  logic              sda_s1_q, sda_s2_q, sda_h_q;
  logic              sda_oe_q, sda_oe_h_q;
  logic              busy_q, wr_pulse_q, rd_pulse_q;
  logic              ack_drv_q, rw_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shreg_q, addr_hi_q;
  logic [MEM_AW-1:0] cur_addr_q;
  logic [7:0]        mem [Depth];

  logic       scl_rise, scl_fall, oe_chg, start_det, stop_det;
  logic       last_bit, rx_state, mem_we;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  // Our own SDA edges must never be mistaken for bus conditions.
  assign oe_chg    = sda_oe_q ^ sda_oe_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q & ~oe_chg;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q & ~oe_chg;
  assign last_bit  = (bit_cnt_q == 4'd7);
  assign rx_byte   = {shreg_q[6:0], sda_s2_q};
  assign rx_state  = (state_q == StDev) || (state_q == StAddrHi) ||
                     (state_q == StAddrLo) || (state_q == StWrData);
  assign mem_we    = rst_n && (state_q == StWrData) && scl_rise && last_bit;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_addr_q] <= rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_h_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_h_q    <= 1'b1;
      sda_oe_q   <= 1'b0;
      sda_oe_h_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
      ack_drv_q  <= 1'b0;
      rw_q       <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      addr_hi_q  <= '0;
      cur_addr_q <= '0;
    end else begin
      scl_s1_q   <= bus.i2c_sclk;
      scl_s2_q   <= scl_s1_q;
      scl_h_q    <= scl_s2_q;
      sda_s1_q   <= i2c_sdat;
      sda_s2_q   <= sda_s1_q;
      sda_h_q    <= sda_s2_q;
      sda_oe_h_q <= sda_oe_q;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;

      if (start_det) begin
        state_q   <= StDev;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        ack_drv_q <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_det) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        ack_drv_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        if (scl_rise && rx_state) begin
          shreg_q   <= rx_byte;
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end

        unique case (state_q)
          StIdle: begin
            busy_q   <= 1'b0;
            sda_oe_q <= 1'b0;
          end

          StDev: begin
            if (scl_rise && last_bit) begin
              bit_cnt_q <= '0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                rw_q    <= rx_byte[0];
                state_q <= StAckDev;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end
          end

          StAddrHi: begin
            if (scl_rise && last_bit) begin
              bit_cnt_q <= '0;
              addr_hi_q <= rx_byte;
              state_q   <= StAckHi;
            end
          end

          StAddrLo: begin
            if (scl_rise && last_bit) begin
              bit_cnt_q  <= '0;
              cur_addr_q <= MEM_AW'({addr_hi_q, rx_byte});
              state_q    <= StAckLo;
            end
          end

          StWrData: begin
            if (scl_rise && last_bit) begin
              bit_cnt_q  <= '0;
              wr_pulse_q <= 1'b1;
              state_q    <= StAckWr;
            end
          end

          // First scl_fall pulls SDA low for the ACK slot, the second releases it.
          StAckDev, StAckHi, StAckLo, StAckWr: begin
            if (scl_fall) begin
              if (!ack_drv_q) begin
                sda_oe_q  <= 1'b1;
                ack_drv_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                ack_drv_q <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == StAckDev) begin
                  state_q <= StAddrHi;
                end else if (state_q == StAckHi) begin
                  state_q <= StAddrLo;
                end else begin
                  state_q <= StWrData;
                  if (state_q == StAckWr) begin
                    cur_addr_q <= cur_addr_q + MEM_AW'(1);
                  end
                end
              end
            end else if (scl_rise && ack_drv_q && rw_q && (state_q == StAckDev)) begin
              // Load during the ACK high phase so bit 7 is ready for the releasing fall.
              ack_drv_q <= 1'b0;
              state_q   <= StRdLoad;
            end
          end

          StRdLoad: begin
            shreg_q    <= mem[cur_addr_q];
            rd_pulse_q <= 1'b1;
            cur_addr_q <= cur_addr_q + MEM_AW'(1);
            bit_cnt_q  <= '0;
            state_q    <= StRdData;
          end

          StRdData: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= StRdAck;
              end else begin
                sda_oe_q  <= ~shreg_q[7];
                shreg_q   <= {shreg_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          StRdAck: begin
            if (scl_rise) begin
`ifdef I2C_SLAVE_SEQ_READ_EN
              if (!sda_s2_q) begin
                state_q <= StRdLoad;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
`else
              state_q <= StIdle;
              busy_q  <= 1'b0;
`endif
            end
          end

          default: begin
            state_q  <= StIdle;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_sdat     = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.wr_pulse = wr_pulse_q;
  assign bus.rd_pulse = rd_pulse_q;
  assign bus.cur_addr = cur_addr_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged I2C master on a pulled-up SDA wire.
module tb_i2c_eeprom_slave;
  localparam int unsigned MEM_AW = 8;
  localparam int Q = 50;  // quarter SCL period = 5 clk

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sda_low = 1'b0;
  wire  sda_bus;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;

  pullup (sda_bus);
  assign sda_bus = sda_low ? 1'b0 : 1'bz;

  i2c_eeprom_slave_if #(.MEM_AW(MEM_AW)) bus_if ();

  i2c_eeprom_slave #(
    .DEV_ADDR(7'h50),
    .MEM_AW  (MEM_AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if.slave),
    .i2c_sdat(sda_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_if.wr_pulse) wr_cnt <= wr_cnt + 1;
    if (bus_if.rd_pulse) rd_cnt <= rd_cnt + 1;
    if (bus_if.sda_oe)   oe_cnt <= oe_cnt + 1;
  end

  task automatic clk_bit(input logic b, output logic s);
    sda_low = ~b;
    #Q bus_if.i2c_sclk = 1'b1;
    #Q s = sda_bus;
    #Q bus_if.i2c_sclk = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, inout int acks);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    if (s === 1'b0) acks++;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~master_ack, s);
  endtask

  task automatic i2c_start;
    sda_low = 1'b0;
    #Q bus_if.i2c_sclk = 1'b1;
    #Q sda_low = 1'b1;
    #Q bus_if.i2c_sclk = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    sda_low = 1'b1;
    #Q bus_if.i2c_sclk = 1'b1;
    #Q sda_low = 1'b0;
    #Q;
  endtask

  task automatic do_write1(input logic [15:0] addr, input logic [7:0] d, output int acks);
    acks = 0;
    i2c_start();
    send_byte(8'hA0, acks);
    send_byte(addr[15:8], acks);
    send_byte(addr[7:0], acks);
    send_byte(d, acks);
    i2c_stop();
  endtask

  task automatic do_read(input logic [15:0] addr, output logic [7:0] d, output int acks);
    acks = 0;
    i2c_start();
    send_byte(8'hA0, acks);
    send_byte(addr[15:8], acks);
    send_byte(addr[7:0], acks);
    i2c_start();
    send_byte(8'hA1, acks);
    recv_byte(1'b0, d);
    i2c_stop();
  endtask

  task automatic test_reset;
    bus_if.i2c_sclk = 1'b1;
    sda_low = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_if.sda_oe, bus_if.busy, bus_if.wr_pulse, bus_if.rd_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus_if.sda_oe, bus_if.busy, bus_if.wr_pulse, bus_if.rd_pulse});
    end
    checks++;
    if (bus_if.cur_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_cur_addr: got %h expected 00", bus_if.cur_addr);
    end
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL reset_sda_line: got %b expected 1", sda_bus);
    end
    rst_n = 1'b1;
    #Q;
  endtask

  task automatic test_write_read;
    int acks = 0;
    int wr0 = wr_cnt;
    int rd0;
    logic [7:0] d;
    i2c_start();
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b expected 1", bus_if.busy);
    end
    send_byte(8'hA0, acks);
    send_byte(8'h00, acks);
    send_byte(8'h34, acks);
    send_byte(8'h12, acks);
    i2c_stop();
    checks++;
    if (acks !== 4) begin
      errors++;
      $display("FAIL write_acks: got %0d expected 4", acks);
    end
    checks++;
    if (wr_cnt - wr0 !== 1) begin
      errors++;
      $display("FAIL write_pulses: got %0d expected 1", wr_cnt - wr0);
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_stop: got %b expected 0", bus_if.busy);
    end
    rd0 = rd_cnt;
    do_read(16'h0034, d, acks);
    checks++;
    if (d !== 8'h12) begin
      errors++;
      $display("FAIL read_data: got %h expected 12", d);
    end
    checks++;
    if (acks !== 4) begin
      errors++;
      $display("FAIL read_acks: got %0d expected 4", acks);
    end
    checks++;
    if (bus_if.cur_addr !== 8'h35) begin
      errors++;
      $display("FAIL read_cur_addr: got %h expected 35", bus_if.cur_addr);
    end
    checks++;
    if (rd_cnt - rd0 !== 1) begin
      errors++;
      $display("FAIL read_pulses: got %0d expected 1", rd_cnt - rd0);
    end
  endtask

  task automatic test_addr_mismatch;
    int acks = 0;
    int wr0 = wr_cnt;
    int oe0 = oe_cnt;
    i2c_start();
    send_byte(8'hA2, acks);
    send_byte(8'h00, acks);
    send_byte(8'h55, acks);
    i2c_stop();
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL mismatch_acks: got %0d expected 0", acks);
    end
    checks++;
    if (oe_cnt !== oe0) begin
      errors++;
      $display("FAIL mismatch_sda_oe: got %0d drive cycles expected 0", oe_cnt - oe0);
    end
    checks++;
    if (wr_cnt !== wr0) begin
      errors++;
      $display("FAIL mismatch_wr: got %0d pulses expected 0", wr_cnt - wr0);
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_busy: got %b expected 0", bus_if.busy);
    end
  endtask

  task automatic test_seq_write_wrap;
    int acks = 0;
    int wr0 = wr_cnt;
    logic [7:0] d;
    logic [15:0] raddr [3] = '{16'h00FE, 16'h00FF, 16'h0000};
    logic [7:0]  rexp  [3] = '{8'h11, 8'h22, 8'h33};
    i2c_start();
    send_byte(8'hA0, acks);
    send_byte(8'h00, acks);
    send_byte(8'hFE, acks);
    send_byte(8'h11, acks);
    send_byte(8'h22, acks);
    send_byte(8'h33, acks);
    i2c_stop();
    checks++;
    if (acks !== 6 || wr_cnt - wr0 !== 3) begin
      errors++;
      $display("FAIL wrap_acks_pulses: got %0d/%0d expected 6/3", acks, wr_cnt - wr0);
    end
    checks++;
    if (bus_if.cur_addr !== 8'h01) begin
      errors++;
      $display("FAIL wrap_cur_addr: got %h expected 01", bus_if.cur_addr);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(raddr[i], d, acks);
      checks++;
      if (d !== rexp[i]) begin
        errors++;
        $display("FAIL wrap_read_%0d: got %h expected %h", i, d, rexp[i]);
      end
    end
  endtask

  task automatic test_addr_trunc;
    int acks;
    logic [7:0] d;
    do_write1(16'h1234, 8'h5A, acks);
    do_read(16'h0034, d, acks);
    checks++;
    if (d !== 8'h5A) begin
      errors++;
      $display("FAIL trunc_read: got %h expected 5a", d);
    end
    checks++;
    if (bus_if.cur_addr !== 8'h35) begin
      errors++;
      $display("FAIL trunc_cur_addr: got %h expected 35", bus_if.cur_addr);
    end
  endtask

  task automatic test_reset_mid_byte;
    int acks = 0;
    int wr0;
    logic s;
    logic [7:0] d;
    do_write1(16'h0010, 8'h77, acks);
    wr0 = wr_cnt;
    acks = 0;
    i2c_start();
    send_byte(8'hA0, acks);
    send_byte(8'h00, acks);
    send_byte(8'h10, acks);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    sda_low = 1'b0;
    #Q bus_if.i2c_sclk = 1'b1;
    #Q;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.sda_oe, bus_if.busy, sda_bus} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_outputs: got %b expected 001",
               {bus_if.sda_oe, bus_if.busy, sda_bus});
    end
    checks++;
    if (bus_if.cur_addr !== 8'h00) begin
      errors++;
      $display("FAIL midrst_cur_addr: got %h expected 00", bus_if.cur_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    #Q bus_if.i2c_sclk = 1'b0;
    #Q;
    i2c_stop();
    do_read(16'h0010, d, acks);
    checks++;
    if (d !== 8'h77 || wr_cnt !== wr0) begin
      errors++;
      $display("FAIL midrst_read: got %h/%0d expected 77/0", d, wr_cnt - wr0);
    end
  endtask

  task automatic test_seq_read;
    int acks = 0;
    int rd0;
    logic [7:0] d1;
    logic [7:0] d2;
    i2c_start();
    send_byte(8'hA0, acks);
    send_byte(8'h00, acks);
    send_byte(8'h20, acks);
    send_byte(8'hA1, acks);
    send_byte(8'hB2, acks);
    i2c_stop();
    rd0 = rd_cnt;
    i2c_start();
    send_byte(8'hA0, acks);
    send_byte(8'h00, acks);
    send_byte(8'h20, acks);
    i2c_start();
    send_byte(8'hA1, acks);
    recv_byte(1'b1, d1);
    checks++;
    if (d1 !== 8'hA1) begin
      errors++;
      $display("FAIL seqrd_byte1: got %h expected a1", d1);
    end
`ifdef I2C_SLAVE_SEQ_READ_EN
    recv_byte(1'b0, d2);
    i2c_stop();
    checks++;
    if (d2 !== 8'hB2) begin
      errors++;
      $display("FAIL seqrd_byte2: got %h expected b2", d2);
    end
    checks++;
    if (rd_cnt - rd0 !== 2) begin
      errors++;
      $display("FAIL seqrd_pulses: got %0d expected 2", rd_cnt - rd0);
    end
`else
    begin
      int oe0 = oe_cnt;
      recv_byte(1'b0, d2);
      checks++;
      if (d2 !== 8'hFF || oe_cnt !== oe0) begin
        errors++;
        $display("FAIL single_rd_release: got %h/%0d expected ff/0", d2, oe_cnt - oe0);
      end
    end
    i2c_stop();
    checks++;
    if (rd_cnt - rd0 !== 1) begin
      errors++;
      $display("FAIL single_rd_pulses: got %0d expected 1", rd_cnt - rd0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_mismatch();
    test_seq_write_wrap();
    test_addr_trunc();
    test_reset_mid_byte();
    test_seq_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
